// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command controller: opcodes, flag bit
// positions inside the 4-bit {C,Z,V,N} vector, and the controller state type.
// Imported by alu_8bit and alu_cmd_ctrl.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_LAST = 3'b100;

  localparam int FLG_C = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_V = 1;
  localparam int FLG_N = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_8bit.sv
// Purpose : combinational 8-bit ALU (ADD, SUB, AND, OR, XOR) with C/Z/V/N flags.
// Latency : 0 cycles, purely combinational.
// Backpr. : none; output follows inputs.
// Ports   : A, B operands; sel opcode; R result; C carry/borrow, Z zero,
//           V signed overflow, N sign. Unknown opcodes give R=0, C=V=0.
module alu_8bit
  import alu_pkg::*;
(
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic [2:0] sel,
  output logic [7:0] R,
  output logic       C,
  output logic       Z,
  output logic       V,
  output logic       N
);

  logic [8:0] sum;
  logic [8:0] diff;

  always_comb begin
    sum  = {1'b0, A} + {1'b0, B};
    // Bit 8 of the 9-bit difference is the borrow (A < B unsigned).
    diff = {1'b0, A} - {1'b0, B};
    R = '0;
    C = 1'b0;
    V = 1'b0;
    case (sel)
      OP_ADD: begin
        R = sum[7:0];
        C = sum[8];
        V = (A[7] == B[7]) && (sum[7] != A[7]);
      end
      OP_SUB: begin
        R = diff[7:0];
        C = diff[8];
        V = (A[7] != B[7]) && (diff[7] != A[7]);
      end
      OP_AND: R = A & B;
      OP_OR:  R = A | B;
      OP_XOR: R = A ^ B;
      default: R = '0;
    endcase
    Z = (R == 8'h00);
    N = R[7];
  end

endmodule

// File: rtl/alu_cmd_ctrl.sv
// Purpose : command-side initiator for alu_8bit with accumulator and sticky flags.
// Latency : command accepted in cycle t -> rsp_valid in cycle t+2; >=3 cycles/command.
// Backpr. : response held stable while rsp_ready=0; cmd_ready low until it drains.
// Ports   : cmd_valid/cmd_ready/cmd_op/cmd_a/cmd_b/cmd_use_acc command channel;
//           rsp_valid/rsp_ready/rsp_r/rsp_flags/rsp_err response channel;
//           acc accumulator, sticky_flags OR-accumulated {C,Z,V,N}, clr_sticky clear.
module alu_cmd_ctrl
  import alu_pkg::*;
#(
  parameter logic [7:0] ACC_INIT = 8'h00,
  parameter bit         ACC_WB   = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  input  logic       cmd_use_acc,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_r,
  output logic [3:0] rsp_flags,
  output logic       rsp_err,
  output logic [7:0] acc,
  output logic [3:0] sticky_flags,
  input  logic       clr_sticky
);

  state_e     state_q, state_d;
  logic       cmd_ready_q, cmd_ready_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] op_a_q, op_a_d;
  logic [7:0] op_b_q, op_b_d;
  logic [2:0] op_sel_q, op_sel_d;
  logic       use_acc_q, use_acc_d;
  logic       err_q, err_d;
  logic [7:0] rsp_r_q, rsp_r_d;
  logic [3:0] rsp_flags_q, rsp_flags_d;
  logic       rsp_err_q, rsp_err_d;
  logic [7:0] acc_q, acc_d;
  logic [3:0] sticky_q, sticky_d;

  logic [7:0] alu_r;
  logic       alu_c, alu_z, alu_v, alu_n;
  logic [3:0] alu_flags;
  logic       exec_legal;

  // The ALU only ever sees the latched operands, so cmd_* may change freely
  // once the command has been taken.
  alu_8bit u_alu (
    .A   (op_a_q),
    .B   (op_b_q),
    .sel (op_sel_q),
    .R   (alu_r),
    .C   (alu_c),
    .Z   (alu_z),
    .V   (alu_v),
    .N   (alu_n)
  );

  always_comb begin
    alu_flags        = '0;
    alu_flags[FLG_C] = alu_c;
    alu_flags[FLG_Z] = alu_z;
    alu_flags[FLG_V] = alu_v;
    alu_flags[FLG_N] = alu_n;
  end

  assign exec_legal = (state_q == EXEC) && !err_q;

  always_comb begin
    state_d     = state_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_sel_d    = op_sel_q;
    use_acc_d   = use_acc_q;
    err_d       = err_q;
    rsp_r_d     = rsp_r_q;
    rsp_flags_d = rsp_flags_q;
    rsp_err_d   = rsp_err_q;
    acc_d       = acc_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          op_a_d    = cmd_use_acc ? acc_q : cmd_a;
          op_b_d    = cmd_b;
          op_sel_d  = cmd_op;
          use_acc_d = cmd_use_acc;
          err_d     = (cmd_op > OP_LAST);
          state_d   = EXEC;
        end
      end
      EXEC: begin
        if (err_q) begin
          rsp_r_d     = '0;
          rsp_flags_d = '0;
          rsp_err_d   = 1'b1;
        end else begin
          rsp_r_d     = alu_r;
          rsp_flags_d = alu_flags;
          rsp_err_d   = 1'b0;
          if (ACC_WB || use_acc_q) begin
            acc_d = alu_r;
          end
        end
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A clear coinciding with a legal EXEC keeps that command's flags.
    sticky_d = (clr_sticky ? 4'b0000 : sticky_q) | (exec_legal ? alu_flags : 4'b0000);

    // Handshake outputs are registered from the next state.
    cmd_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_sel_q    <= '0;
      use_acc_q   <= 1'b0;
      err_q       <= 1'b0;
      rsp_r_q     <= '0;
      rsp_flags_q <= '0;
      rsp_err_q   <= 1'b0;
      acc_q       <= ACC_INIT;
      sticky_q    <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_sel_q    <= op_sel_d;
      use_acc_q   <= use_acc_d;
      err_q       <= err_d;
      rsp_r_q     <= rsp_r_d;
      rsp_flags_q <= rsp_flags_d;
      rsp_err_q   <= rsp_err_d;
      acc_q       <= acc_d;
      sticky_q    <= sticky_d;
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_r        = rsp_r_q;
  assign rsp_flags    = rsp_flags_q;
  assign rsp_err      = rsp_err_q;
  assign acc          = acc_q;
  assign sticky_flags = sticky_q;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Bench for alu_cmd_ctrl: directed literal checks plus randomized traffic,
// with a transaction-level reference model compared every cycle.
module tb_alu_cmd_ctrl;
  import alu_pkg::*;

  localparam logic [7:0] P_ACC_INIT = 8'h00;
  localparam bit         P_ACC_WB   = 1'b1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic       cmd_use_acc;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_r;
  logic [3:0] rsp_flags;
  logic       rsp_err;
  logic [7:0] acc;
  logic [3:0] sticky_flags;
  logic       clr_sticky;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  alu_cmd_ctrl #(.ACC_INIT(P_ACC_INIT), .ACC_WB(P_ACC_WB)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_r(rsp_r),
    .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .acc(acc), .sticky_flags(sticky_flags), .clr_sticky(clr_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference ALU from plain integer arithmetic.
  function automatic void ref_alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] r, output logic [3:0] f, output logic e);
    int ua, ub, sa, sb, full, sfull;
    logic c, v;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    c = 1'b0; v = 1'b0; e = 1'b0; r = 8'h00; f = 4'h0;
    case (op)
      3'd0: begin full = ua + ub; sfull = sa + sb; r = full[7:0]; c = (full > 255); v = (sfull > 127) || (sfull < -128); end
      3'd1: begin full = ua - ub; sfull = sa - sb; r = full[7:0]; c = (ua < ub);   v = (sfull > 127) || (sfull < -128); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      default: e = 1'b1;
    endcase
    if (!e) f = {c, (r == 8'h00), v, r[7]};
  endfunction

  // Transaction-level model: one command in flight, counted in cycles since accept.
  logic [7:0] m_acc;
  logic [3:0] m_sticky;
  logic [7:0] m_last_r;
  logic [3:0] m_last_f;
  logic       m_last_e;
  bit         m_busy;
  bit         m_rdy;
  int         m_age;
  logic [2:0] p_op;
  logic [7:0] p_a, p_b;
  logic       p_ua;
  logic [7:0] t_r;
  logic [3:0] t_f, t_nf;
  logic       t_e;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_acc = P_ACC_INIT; m_sticky = 4'h0;
      m_last_r = 8'h00; m_last_f = 4'h0; m_last_e = 1'b0;
      m_busy = 1'b0; m_rdy = 1'b0; m_age = 0;
    end else begin
      t_nf = 4'h0;
      if (m_busy) begin
        if (m_age == 1) begin
          ref_alu(p_op, p_a, p_b, t_r, t_f, t_e);
          m_last_r = t_r; m_last_f = t_f; m_last_e = t_e;
          if (!t_e) begin
            t_nf = t_f;
            if (P_ACC_WB || p_ua) m_acc = t_r;
          end
        end else if (rsp_ready) begin
          m_busy = 1'b0;
        end
        m_age++;
      end else if (m_rdy && cmd_valid) begin
        p_op = cmd_op; p_b = cmd_b; p_ua = cmd_use_acc;
        p_a = cmd_use_acc ? m_acc : cmd_a;
        m_busy = 1'b1; m_age = 1;
      end
      m_sticky = (clr_sticky ? 4'h0 : m_sticky) | t_nf;
      m_rdy = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_cmd_ready", 32'(cmd_ready), 32'(m_rdy && !m_busy));
      chk("m_rsp_valid", 32'(rsp_valid), 32'(m_busy && (m_age >= 2)));
      chk("m_rsp_r", 32'(rsp_r), 32'(m_last_r));
      chk("m_rsp_flags", 32'(rsp_flags), 32'(m_last_f));
      chk("m_rsp_err", 32'(rsp_err), 32'(m_last_e));
      chk("m_acc", 32'(acc), 32'(m_acc));
      chk("m_sticky", 32'(sticky_flags), 32'(m_sticky));
    end
  end

  // Called at a negedge with the DUT idle or about to be; returns at the
  // negedge of the EXEC cycle with clr_sticky set for that cycle.
  task automatic accept(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic ua, input logic clr);
    int n;
    n = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = ua;
    while (cmd_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("accept_timeout", 32'(n), 32'(0));
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = 3'($urandom); cmd_a = 8'($urandom); cmd_b = 8'($urandom);
    cmd_use_acc = 1'($urandom);
    clr_sticky = clr;
    chk("lat_t1_valid", 32'(rsp_valid), 32'(0));
  endtask

  task automatic finish_cmd(input string name, input logic [7:0] er, input logic [3:0] ef,
                            input logic ee, input logic [7:0] eacc);
    @(negedge clk);
    clr_sticky = 1'b0;
    chk({name, "_t2_valid"}, 32'(rsp_valid), 32'(1));
    chk({name, "_r"}, 32'(rsp_r), 32'(er));
    chk({name, "_flags"}, 32'(rsp_flags), 32'(ef));
    chk({name, "_err"}, 32'(rsp_err), 32'(ee));
    chk({name, "_acc"}, 32'(acc), 32'(eacc));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({name, "_drop"}, 32'(rsp_valid), 32'(0));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog at %0t: got timeout expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_a = 8'd0; cmd_b = 8'd0;
    cmd_use_acc = 1'b0; rsp_ready = 1'b0; clr_sticky = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'(0));
    chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("rst_rsp_r", 32'(rsp_r), 32'(0));
    chk("rst_acc", 32'(acc), 32'(P_ACC_INIT));
    chk("rst_sticky", 32'(sticky_flags), 32'(0));
    chk_en = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);

    accept(OP_ADD, 8'd20, 8'd10, 1'b0, 1'b0);  finish_cmd("add20_10", 8'd30, 4'b0000, 1'b0, 8'd30);
    accept(OP_ADD, 8'hAA, 8'd5, 1'b1, 1'b0);   finish_cmd("add_acc", 8'd35, 4'b0000, 1'b0, 8'd35);
    accept(OP_ADD, 8'd200, 8'd100, 1'b0, 1'b0); finish_cmd("add_carry", 8'h2C, 4'b1000, 1'b0, 8'h2C);
    chk("sticky_c", 32'(sticky_flags), 32'(4'b1000));
    accept(OP_SUB, 8'd50, 8'd50, 1'b0, 1'b0);  finish_cmd("sub_zero", 8'd0, 4'b0100, 1'b0, 8'd0);
    accept(OP_SUB, 8'd5, 8'd10, 1'b0, 1'b0);   finish_cmd("sub_neg", 8'hFB, 4'b1001, 1'b0, 8'hFB);
    accept(OP_AND, 8'd12, 8'd5, 1'b0, 1'b0);   finish_cmd("and", 8'd4, 4'b0000, 1'b0, 8'd4);
    accept(OP_OR,  8'd12, 8'd5, 1'b0, 1'b0);   finish_cmd("or", 8'd13, 4'b0000, 1'b0, 8'd13);
    accept(OP_XOR, 8'd12, 8'd5, 1'b0, 1'b0);   finish_cmd("xor", 8'd9, 4'b0000, 1'b0, 8'd9);
    accept(3'b110, 8'd1, 8'd2, 1'b0, 1'b0);    finish_cmd("illegal", 8'd0, 4'b0000, 1'b1, 8'd9);
    chk("illegal_sticky", 32'(sticky_flags), 32'(4'b1101));

    // Backpressure: response held for five cycles, a stray command is refused.
    accept(OP_ADD, 8'd1, 8'd1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(rsp_valid), 32'(1));
      chk("bp_r", 32'(rsp_r), 32'(2));
      chk("bp_flags", 32'(rsp_flags), 32'(0));
      chk("bp_cmd_ready", 32'(cmd_ready), 32'(0));
      cmd_valid = (i == 2); cmd_a = 8'd9; cmd_b = 8'd9; cmd_op = OP_ADD;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp_drop", 32'(rsp_valid), 32'(0));
    chk("bp_acc", 32'(acc), 32'(2));
    @(negedge clk);

    // Clear in the same cycle as an EXEC producing Z keeps only Z.
    accept(OP_SUB, 8'd7, 8'd7, 1'b0, 1'b1);    finish_cmd("clr_exec", 8'd0, 4'b0100, 1'b0, 8'd0);
    chk("clr_exec_sticky", 32'(sticky_flags), 32'(4'b0100));

    // Reset during EXEC aborts the command.
    accept(OP_ADD, 8'd3, 8'd4, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid), 32'(0));
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'(0));
    chk("mid_rst_acc", 32'(acc), 32'(P_ACC_INIT));
    chk("mid_rst_r", 32'(rsp_r), 32'(0));
    chk("mid_rst_sticky", 32'(sticky_flags), 32'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_rsp_after_rst", 32'(rsp_valid), 32'(0));
    end

    // Randomized traffic against the model.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      cmd_valid   = 1'($urandom);
      cmd_op      = 3'($urandom);
      cmd_a       = 8'($urandom);
      cmd_b       = 8'($urandom);
      cmd_use_acc = 1'($urandom);
      rsp_ready   = ($urandom_range(0, 2) != 0);
      clr_sticky  = ($urandom_range(0, 7) == 0);
      if (cyc % 997 == 500) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    @(negedge clk);
    cmd_valid = 1'b0; rsp_ready = 1'b0; clr_sticky = 1'b0;
    @(negedge clk);
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
